cmd_seq: RTL and testbench
==========================

CMD_SEQ -- requirements
Module: cmd_seq

Interface
REQ-001 Parameter TMO_CYCLES, default 24'd2_000_000, is the wait-state timeout in clk cycles.
REQ-002 Parameter ACK, default 8'hA5, is the positive response byte.
REQ-003 Parameter NAK, default 8'hEE, is the negative response byte for timeout or unknown opcode.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd  in  16  command word from the UART wrapper; opcode is cmd[15:13].
REQ-007 cmd_rdy  in  1  level; cmd is valid and pending.
REQ-008 clr_cmd_rdy  out  1  one-cycle pulse consuming the pending cmd.
REQ-009 send_resp  out  1  one-cycle pulse; resp is valid in the same cycle.
REQ-010 resp  out  8  response byte.
REQ-011 strt_cal  out  1  one-cycle pulse to start inertial calibration.
REQ-012 cal_done  in  1  calibration finished; may be a pulse or a level.
REQ-013 strt_hdg  out  1  one-cycle pulse to start a heading change.
REQ-014 dsrd_hdg  out  12  desired heading, held until next heading command.
REQ-015 strt_mv  out  1  one-cycle pulse to start a forward move.
REQ-016 stp_lft, stp_rght  out  1 each  move stop-at-opening qualifiers, held.
REQ-017 mv_cmplt  in  1  heading or move finished.
REQ-018 strt_slv  out  1  one-cycle pulse to start the maze solver.
REQ-019 cmd_md  out  1  solver affinity (1 = left), held.
REQ-020 sol_cmplt  in  1  solver found the magnet.

Function
REQ-021 The states SHALL be IDLE, CAL, HDG, MV and SLV.
REQ-022 In IDLE with cmd_rdy=1, the block SHALL pulse clr_cmd_rdy and decode the opcode in the same cycle.
REQ-023 Opcode 000 SHALL pulse strt_cal and go to CAL.
REQ-024 Opcode 001 SHALL load dsrd_hdg<=cmd[11:0], pulse strt_hdg and go to HDG.
REQ-025 Opcode 010 SHALL load stp_lft<=cmd[1] and stp_rght<=cmd[0], pulse strt_mv and go to MV.
REQ-026 Opcode 011 SHALL load cmd_md<=cmd[0], pulse strt_slv and go to SLV.
REQ-027 Any other opcode SHALL pulse send_resp with resp=NAK and stay in IDLE.
REQ-028 The completion events SHALL be cal_done in CAL, mv_cmplt in HDG and MV, and sol_cmplt in SLV.
REQ-029 On its completion event, the block SHALL pulse send_resp with resp=ACK one cycle after that event is sampled, then return to IDLE.
REQ-030 A single timeout counter SHALL clear on every state entry and increment every cycle while in CAL, HDG, MV or SLV.
REQ-031 When the counter reaches TMO_CYCLES-1, the block SHALL pulse send_resp with resp=NAK and return to IDLE.
REQ-032 If a completion event and the timeout occur in the same cycle, the completion SHALL win (ACK).
REQ-033 The counter SHALL saturate and never wrap.
REQ-034 A cmd_rdy arriving outside IDLE SHALL be left pending: no clr_cmd_rdy is issued; it is accepted on the first IDLE cycle.
REQ-035 A completion input asserted while in IDLE, or while in a state it does not complete, SHALL be ignored.
REQ-036 resp SHALL hold its last value between send_resp pulses.
REQ-037 At most one strt_* pulse SHALL be issued per accepted command.

Reset
REQ-038 Asserting rst, including mid-command, SHALL immediately set: state=IDLE; counter=0; resp=8'h00; dsrd_hdg=12'h000; stp_lft, stp_rght and cmd_md=0; all pulse outputs=0.
REQ-039 An aborted command SHALL produce no response.

Structure
REQ-040 A shared package cmd_seq_pkg SHALL hold the state enum, the 3-bit opcode constants (OP_CAL, OP_HDG, OP_MV, OP_SLV), and the ACK and NAK defaults.
REQ-041 The timeout counter SHALL be the sub-module tmo_cntr (inputs clr and en; output expired).

Verification
REQ-042 cmd=16'h0000 with cmd_rdy; pulse cal_done 500 cycles later -> one strt_cal pulse, then send_resp with resp=8'hA5 one cycle after cal_done.
REQ-043 cmd=16'h23FF; mv_cmplt after 100 cycles -> dsrd_hdg=12'h3FF, strt_hdg pulse, resp=8'hA5.
REQ-044 cmd=16'h6000 with TMO_CYCLES=1000 and no sol_cmplt -> strt_slv pulse, cmd_md=0, resp=8'hEE at cycle 1000, state back to IDLE.
REQ-045 cmd=16'hE000 -> no strt_* pulse; send_resp with resp=8'hEE in the acceptance cycle.
REQ-046 A second cmd_rdy during MV -> clr_cmd_rdy held off until after the MV ACK; the second command then executes.
REQ-047 rst asserted 10 cycles into CAL -> all outputs at reset values; a later cal_done produces no send_resp.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared states, opcodes and response defaults for the command sequencer.
package cmd_seq_pkg;
    typedef enum logic [2:0] {IDLE, CAL, HDG, MV, SLV} state_t;
    localparam logic [2:0] OP_CAL = 3'd0;
    localparam logic [2:0] OP_HDG = 3'd1;
    localparam logic [2:0] OP_MV = 3'd2;
    localparam logic [2:0] OP_SLV = 3'd3;
    localparam logic [7:0] ACK_DEF = 8'hA5;
    localparam logic [7:0] NAK_DEF = 8'hEE;
endpackage

// File: rtl/tmo_cntr.sv
// tmo_cntr: saturating wait-state counter; expired marks the last allowed cycle.
module tmo_cntr #(
    parameter logic [23:0] TMO_CYCLES = 24'd2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [23:0] cnt;
    assign expired = cnt == TMO_CYCLES - 24'd1;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 24'd1;
endmodule

// File: rtl/cmd_seq.sv
// cmd_seq: decodes UART commands, starts the matching engine and answers ACK on
// completion or NAK on timeout / unknown opcode.
module cmd_seq
    import cmd_seq_pkg::*;
#(
    parameter logic [23:0] TMO_CYCLES = 24'd2_000_000,
    parameter logic [7:0] ACK = ACK_DEF,
    parameter logic [7:0] NAK = NAK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    output logic        strt_cal,
    input  logic        cal_done,
    output logic        strt_hdg,
    output logic [11:0] dsrd_hdg,
    output logic        strt_mv,
    output logic        stp_lft,
    output logic        stp_rght,
    input  logic        mv_cmplt,
    output logic        strt_slv,
    output logic        cmd_md,
    input  logic        sol_cmplt
);
    state_t state, nxt;
    logic [2:0] op;
    logic [7:0] resp_q;
    logic busy, acc, bad_op, done_ev, expired, tmo_nak, ack_q, unused_cmd;
    assign op = cmd[15:13];
    assign unused_cmd = cmd[12];
    assign busy = state != IDLE;
    // The ACK cycle already lands in IDLE; holding acceptance off keeps send_resp unambiguous.
    assign acc = !rst && state == IDLE && cmd_rdy && !ack_q;
    assign bad_op = acc && op > OP_SLV;
    assign done_ev = state == CAL ? cal_done :
                     (state == HDG || state == MV) ? mv_cmplt :
                     state == SLV ? sol_cmplt : 1'b0;
    assign tmo_nak = busy && expired && !done_ev;
    assign clr_cmd_rdy = acc;
    assign strt_cal = acc && op == OP_CAL;
    assign strt_hdg = acc && op == OP_HDG;
    assign strt_mv = acc && op == OP_MV;
    assign strt_slv = acc && op == OP_SLV;
    assign send_resp = ack_q || tmo_nak || bad_op;
    assign resp = (tmo_nak || bad_op) ? NAK : resp_q;
    always_comb begin
        nxt = state;
        if (acc)
            nxt = op == OP_CAL ? CAL : op == OP_HDG ? HDG : op == OP_MV ? MV : op == OP_SLV ? SLV : IDLE;
        else if (busy && (done_ev || expired))
            nxt = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            ack_q <= 1'b0;
            resp_q <= 8'h00;
            dsrd_hdg <= 12'h000;
            stp_lft <= 1'b0;
            stp_rght <= 1'b0;
            cmd_md <= 1'b0;
        end else begin
            state <= nxt;
            ack_q <= busy && done_ev;
            if (busy && done_ev) resp_q <= ACK;
            else if (tmo_nak || bad_op) resp_q <= NAK;
            if (strt_hdg) dsrd_hdg <= cmd[11:0];
            if (strt_mv) {stp_lft, stp_rght} <= cmd[1:0];
            if (strt_slv) cmd_md <= cmd[0];
        end
    tmo_cntr #(.TMO_CYCLES(TMO_CYCLES)) u_tmo (
        .clk(clk),
        .rst(rst),
        .clr(nxt != state),
        .en(busy),
        .expired(expired)
    );
endmodule

// File: tb/tb_cmd_seq.sv
// tb_cmd_seq: directed stimulus with a cycle-counting reference model checked every cycle.
module tb_cmd_seq;
    localparam logic [23:0] TMO = 24'd1000;
    localparam logic [7:0] ACKV = 8'hA5;
    localparam logic [7:0] NAKV = 8'hEE;
    logic clk = 0, rst = 1, cmd_rdy = 0, cal_done = 0, mv_cmplt = 0, sol_cmplt = 0;
    logic [15:0] cmd = 16'h0000;
    logic clr_cmd_rdy, send_resp, strt_cal, strt_hdg, strt_mv, stp_lft, stp_rght, strt_slv, cmd_md;
    logic [7:0] resp;
    logic [11:0] dsrd_hdg;
    int n_cmp = 0, n_bad = 0, cyc = 0;

    cmd_seq #(.TMO_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp(resp), .strt_cal(strt_cal), .cal_done(cal_done),
        .strt_hdg(strt_hdg), .dsrd_hdg(dsrd_hdg), .strt_mv(strt_mv), .stp_lft(stp_lft),
        .stp_rght(stp_rght), .mv_cmplt(mv_cmplt), .strt_slv(strt_slv), .cmd_md(cmd_md),
        .sol_cmplt(sol_cmplt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: an engine is busy from the cycle after acceptance; it times out
    // TMO cycles after acceptance unless its own completion input is high then.
    int m_kind = 0, m_start = 0;
    bit m_ack = 0;
    logic [7:0] m_resp = 8'h00;
    logic [11:0] m_hdg = 12'h000;
    logic m_l = 0, m_r = 0, m_md = 0;
    always @(negedge clk) begin
        logic [2:0] op;
        bit acc, bad, done, tmo;
        int e;
        if (rst) begin
            m_kind = 0; m_ack = 0; m_resp = 8'h00; m_hdg = 12'h000; m_l = 0; m_r = 0; m_md = 0;
        end
        op = cmd[15:13];
        e = cyc - m_start;
        acc = !rst && m_kind == 0 && !m_ack && cmd_rdy;
        bad = acc && op > 3'd3;
        done = !rst && (m_kind == 1 ? cal_done : (m_kind == 2 || m_kind == 3) ? mv_cmplt :
                        m_kind == 4 ? sol_cmplt : 1'b0);
        tmo = !rst && m_kind != 0 && e == int'(TMO) && !done;
        check("m_clr_cmd_rdy", clr_cmd_rdy, acc);
        check("m_strt_cal", strt_cal, acc && op == 3'd0);
        check("m_strt_hdg", strt_hdg, acc && op == 3'd1);
        check("m_strt_mv", strt_mv, acc && op == 3'd2);
        check("m_strt_slv", strt_slv, acc && op == 3'd3);
        check("m_send_resp", send_resp, !rst && (m_ack || bad || tmo));
        check("m_resp", resp, (bad || tmo) ? NAKV : m_resp);
        check("m_dsrd_hdg", dsrd_hdg, m_hdg);
        check("m_stops", {stp_lft, stp_rght}, {m_l, m_r});
        check("m_cmd_md", cmd_md, m_md);
        if (!rst) begin
            m_ack = 0;
            if (bad || tmo) m_resp = NAKV;
            if (acc && !bad) begin
                m_kind = int'(op) + 1;
                m_start = cyc;
                if (op == 3'd1) m_hdg = cmd[11:0];
                if (op == 3'd2) {m_l, m_r} = cmd[1:0];
                if (op == 3'd3) m_md = cmd[0];
            end else if (done) begin
                m_kind = 0; m_ack = 1; m_resp = ACKV;
            end else if (tmo) m_kind = 0;
        end
    end

    initial begin
        int k;
        tick(3);
        @(negedge clk);
        check("reset resp", resp, 8'h00);
        check("reset held", {dsrd_hdg, stp_lft, stp_rght, cmd_md}, 15'h0);
        tick(1); rst = 0;
        tick(2);
        // calibration, with a wrong completion input ignored along the way
        cmd = 16'h0000; cmd_rdy = 1;
        @(negedge clk); check("cal accept", {clr_cmd_rdy, strt_cal, send_resp}, 3'b110);
        tick(1); cmd_rdy = 0; mv_cmplt = 1;
        tick(1); mv_cmplt = 0;
        tick(498); cal_done = 1;
        tick(1); cal_done = 0;
        @(negedge clk); check("cal ack", {send_resp, resp}, {1'b1, 8'hA5});
        // heading
        tick(2); cmd = 16'h23FF; cmd_rdy = 1;
        @(negedge clk); check("hdg accept", {clr_cmd_rdy, strt_hdg}, 2'b11);
        tick(1); cmd_rdy = 0;
        tick(99); mv_cmplt = 1;
        tick(1); mv_cmplt = 0;
        @(negedge clk); check("hdg ack", {send_resp, resp}, {1'b1, 8'hA5});
        check("hdg value", dsrd_hdg, 12'h3FF);
        // solver timeout
        tick(2); cmd = 16'h6000; cmd_rdy = 1;
        @(negedge clk); check("slv accept", strt_slv, 1'b1);
        tick(1); cmd_rdy = 0;
        @(negedge clk); check("slv cmd_md", cmd_md, 1'b0);
        k = 1;
        while (!send_resp && k < 1100) begin
            @(posedge clk); @(negedge clk); k++;
        end
        check("slv timeout cycle", k, 1000);
        check("slv timeout resp", resp, 8'hEE);
        // unknown opcode, accepted immediately after the timeout
        tick(1); cmd = 16'hE000; cmd_rdy = 1;
        @(negedge clk);
        check("bad op", {send_resp, resp, clr_cmd_rdy, strt_cal, strt_hdg, strt_mv, strt_slv},
              {1'b1, 8'hEE, 1'b1, 4'b0000});
        tick(1); cmd_rdy = 0; cal_done = 1; mv_cmplt = 1; sol_cmplt = 1;
        tick(1); cal_done = 0; mv_cmplt = 0; sol_cmplt = 0;
        @(negedge clk); check("idle ignore", send_resp, 1'b0);
        // move with a second command pending
        tick(1); cmd = 16'h4003; cmd_rdy = 1;
        @(negedge clk); check("mv accept", {clr_cmd_rdy, strt_mv}, 2'b11);
        tick(1); cmd = 16'h2123;
        @(negedge clk); check("mv stops", {stp_lft, stp_rght, clr_cmd_rdy}, 3'b110);
        tick(19); mv_cmplt = 1;
        tick(1); mv_cmplt = 0;
        @(negedge clk); check("mv ack", {send_resp, resp, clr_cmd_rdy}, {1'b1, 8'hA5, 1'b0});
        tick(1);
        @(negedge clk); check("second accept", {clr_cmd_rdy, strt_hdg}, 2'b11);
        tick(1); cmd_rdy = 0;
        @(negedge clk); check("second hdg", dsrd_hdg, 12'h123);
        tick(5); mv_cmplt = 1;
        tick(1); mv_cmplt = 0;
        @(negedge clk); check("second ack", {send_resp, resp}, {1'b1, 8'hA5});
        // completion coincident with timeout: completion wins
        tick(2); cmd = 16'h6001; cmd_rdy = 1;
        tick(1); cmd_rdy = 0;
        tick(999); sol_cmplt = 1;
        @(negedge clk); check("tie no nak", send_resp, 1'b0);
        tick(1); sol_cmplt = 0;
        @(negedge clk); check("tie ack", {send_resp, resp, cmd_md}, {1'b1, 8'hA5, 1'b1});
        // reset mid-calibration
        tick(2); cmd = 16'h0000; cmd_rdy = 1;
        tick(1); cmd_rdy = 0;
        tick(9); rst = 1;
        @(negedge clk);
        check("abort reset", {resp, dsrd_hdg, stp_lft, stp_rght, cmd_md, clr_cmd_rdy, send_resp,
              strt_cal, strt_hdg, strt_mv, strt_slv}, 29'h0);
        tick(1); rst = 0;
        tick(20); cal_done = 1;
        tick(1); cal_done = 0;
        @(negedge clk); check("abort silent", send_resp, 1'b0);
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
